deserializer_pkt: RTL and testbench
===================================

# deserializer_pkt

Parametrised serial-to-parallel converter with selectable bit order, packet-end flush of partial words, and ready/valid backpressure on both sides. It sits between a bit-serial source and word-wide consumers and is the successor to the fixed 16-bit deserializer. Unlike that block, it can report a short final word and can stall its source when the consumer is not ready.

## Interface
- DATA_W, 16: output word width in bits; legal range 2..64.
- MSB_FIRST, 1: 1 = first received bit lands in the most significant valid position; 0 = first received bit lands in bit 0.
- CNT_W, $clog2(DATA_W+1): width of the bit counter and length field; derived, never overridden.
- clk_i  in  1  single clock; all logic is on the rising edge.
- srst_n_i  in  1  reset, synchronous and active-low.
- data_i  in  1  serial data bit.
- data_val_i  in  1  data_i is valid this cycle.
- data_last_i  in  1  this bit ends the packet; qualified by data_val_i.
- data_rdy_o  out  1  block accepts a bit this cycle; a bit is accepted when data_val_i && data_rdy_o.
- deser_data_o  out  DATA_W  assembled word; only the low deser_len_o bits are meaningful, upper bits are 0.
- deser_len_o  out  CNT_W  number of valid bits, 1..DATA_W.
- deser_last_o  out  1  word is the final word of a packet.
- deser_data_val_o  out  1  output word valid.
- deser_data_rdy_i  in  1  consumer accepts the word; transfer occurs when deser_data_val_o && deser_data_rdy_i.

## Operation
- Datapath: an assembly register (shift register plus bit_cnt) feeds an output holding register.
- Bit accept, MSB_FIRST=1: asm <= {asm[DATA_W-2:0], data_i}. With a right-justified result, the first bit ends at position len-1.
- Bit accept, MSB_FIRST=0: data_i is written to asm[bit_cnt]. The first bit ends at bit 0.
- bit_cnt increments per accepted bit.
- Word completion occurs on an accepted bit when bit_cnt == DATA_W-1 or data_last_i == 1. On completion:
  - the holding register loads asm (including the current bit) with upper unused bits forced to 0;
  - deser_len_o <= bit_cnt+1 and deser_last_o <= data_last_i;
  - asm and bit_cnt clear to 0 in the same cycle.
- A full word that also carries data_last_i produces len = DATA_W and last = 1.
- data_rdy_o = !deser_data_val_o || deser_data_rdy_i. This is combinational from deser_data_rdy_i and is a documented path.
- data_rdy_o is the only stall mechanism. Bits are never dropped: an unaccepted bit (data_val_i=1, data_rdy_o=0) is held by the source.
- Holding register:
  - set on completion;
  - cleared on transfer with no completion in the same cycle;
  - on simultaneous transfer and completion, the new word loads and deser_data_val_o stays 1.
- Output fields are stable while deser_data_val_o=1 and deser_data_rdy_i=0.
- bit_cnt arithmetic is unsigned CNT_W. It never exceeds DATA_W-1 between words and has no wrap path.

## Timing
- Reset (srst_n_i=0 at a clock edge) sets bit_cnt=0, asm=0, deser_data_o=0, deser_len_o=0, deser_last_o=0, deser_data_val_o=0. data_rdy_o is therefore 1 in the following cycle.
- Reset mid-word discards all partial bits. A pending output word is discarded without transfer.
- Latency: deser_data_val_o rises on the edge that accepts the completing bit and is visible from the next cycle.
- Throughput: 1 bit/cycle sustained when deser_data_rdy_i stays high. A word completing every DATA_W cycles never stalls.
- With deser_data_rdy_i low and a word pending, data_rdy_o=0. No bit is accepted until the cycle the word is taken, and a bit may be accepted in that same cycle.
- data_last_i and data_i are ignored when data_val_i=0.

## Test plan
- Reset and idle: srst_n_i=0 for 2 cycles, then release. All outputs are 0 and data_rdy_o=1. Held reset with toggling data_val_i produces no output.
- Full word, DATA_W=16, MSB_FIRST=1: send 0xA5C3 MSB first, contiguous, consumer always ready.
  - One val pulse with deser_data_o=0xA5C3, len=16, last=0, one cycle after bit 16.
  - Back-to-back words give continuous 1-in-16 val pulses.
- LSB order and short packet, DATA_W=8, MSB_FIRST=0: send bits 1,0,1 with last on the third. Output is 8'h05, len=3, last=1; the next word starts at bit 0.
- MSB short packet, DATA_W=8: send 1,1,0 with last. Output is 8'h06, len=3, last=1.
- Backpressure: hold deser_data_rdy_i=0 across two completed words with the source always valid.
  - data_rdy_o drops after the first word and the output stays stable.
  - Raising rdy transfers word 1, and the bit stream resumes in the same cycle.
  - Word 2 is intact, with no lost or duplicated bits.
- Reset mid-word: send 7 of 16 bits, pulse srst_n_i low for 1 cycle, then send a full word 0x1234. Output is exactly 0x1234 with len=16.

Source files
------------

// File: rtl/deserializer_pkt.sv
// Bit-serial to word-parallel converter with packet-end flush of short words
// and ready/valid handshakes on both the serial input and the word output.
module deserializer_pkt #(
    parameter int DATA_W    = 16,
    parameter bit MSB_FIRST = 1'b1,
    parameter int CNT_W     = $clog2(DATA_W + 1)
) (
    input  logic              clk_i,
    input  logic              srst_n_i,
    input  logic              data_i,
    input  logic              data_val_i,
    input  logic              data_last_i,
    output logic              data_rdy_o,
    output logic [DATA_W-1:0] deser_data_o,
    output logic [CNT_W-1:0]  deser_len_o,
    output logic              deser_last_o,
    output logic              deser_data_val_o,
    input  logic              deser_data_rdy_i
);

    logic [DATA_W-1:0] r_asm;
    logic [CNT_W-1:0]  r_bit_cnt;
    logic [DATA_W-1:0] r_data;
    logic [CNT_W-1:0]  r_len;
    logic              r_last;
    logic              r_val;

    logic [DATA_W-1:0] w_asm_nxt;
    logic [DATA_W-1:0] w_mask;
    logic [CNT_W-1:0]  w_len;
    logic              w_accept;
    logic              w_xfer;
    logic              w_done;

    // Ready is combinational from the consumer so a word taken this cycle frees the slot at once.
    assign data_rdy_o = !r_val || deser_data_rdy_i;
    assign w_accept   = data_val_i && data_rdy_o;
    assign w_xfer     = r_val && deser_data_rdy_i;
    assign w_len      = r_bit_cnt + CNT_W'(1);
    assign w_done     = w_accept && ((r_bit_cnt == CNT_W'(DATA_W - 1)) || data_last_i);

    always_comb begin
        w_asm_nxt = r_asm;
        if (MSB_FIRST) begin
            w_asm_nxt = {r_asm[DATA_W-2:0], data_i};
        end else begin
            for (int i = 0; i < DATA_W; i++) begin
                if (CNT_W'(i) == r_bit_cnt) begin
                    w_asm_nxt[i] = data_i;
                end
            end
        end
    end

    always_comb begin
        w_mask = '0;
        for (int i = 0; i < DATA_W; i++) begin
            w_mask[i] = (CNT_W'(i) < w_len);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!srst_n_i) begin
            r_asm     <= '0;
            r_bit_cnt <= '0;
        end else if (w_accept) begin
            if (w_done) begin
                r_asm     <= '0;
                r_bit_cnt <= '0;
            end else begin
                r_asm     <= w_asm_nxt;
                r_bit_cnt <= w_len;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!srst_n_i) begin
            r_data <= '0;
            r_len  <= '0;
            r_last <= 1'b0;
            r_val  <= 1'b0;
        end else if (w_done) begin
            // A completion wins over a same-cycle transfer: the new word replaces the old.
            r_data <= w_asm_nxt & w_mask;
            r_len  <= w_len;
            r_last <= data_last_i;
            r_val  <= 1'b1;
        end else if (w_xfer) begin
            r_data <= '0;
            r_len  <= '0;
            r_last <= 1'b0;
            r_val  <= 1'b0;
        end
    end

    assign deser_data_o     = r_data;
    assign deser_len_o      = r_len;
    assign deser_last_o     = r_last;
    assign deser_data_val_o = r_val;

endmodule

// File: tb/tb_deserializer_pkt.sv
// Bench for deserializer_pkt: three instances (16/MSB, 8/LSB, 8/MSB) checked every cycle
// against a bit-list reference model, with directed packets and random traffic.
module tb_deserializer_pkt;

    logic clk = 1'b0;
    logic srst_n = 1'b0;
    always #5 clk = ~clk;

    logic din[3];
    logic dval[3];
    logic dlast[3];
    logic crdy[3];
    logic drdy[3];
    logic oval[3];
    logic olast[3];
    logic [63:0] odata[3];
    logic [63:0] olen[3];

    logic [15:0] q0;
    logic [4:0]  l0;
    logic [7:0]  q1, q2;
    logic [3:0]  l1, l2;

    deserializer_pkt #(.DATA_W(16), .MSB_FIRST(1'b1)) u_w16_msb (
        .clk_i(clk), .srst_n_i(srst_n), .data_i(din[0]), .data_val_i(dval[0]),
        .data_last_i(dlast[0]), .data_rdy_o(drdy[0]), .deser_data_o(q0), .deser_len_o(l0),
        .deser_last_o(olast[0]), .deser_data_val_o(oval[0]), .deser_data_rdy_i(crdy[0])
    );
    deserializer_pkt #(.DATA_W(8), .MSB_FIRST(1'b0)) u_w8_lsb (
        .clk_i(clk), .srst_n_i(srst_n), .data_i(din[1]), .data_val_i(dval[1]),
        .data_last_i(dlast[1]), .data_rdy_o(drdy[1]), .deser_data_o(q1), .deser_len_o(l1),
        .deser_last_o(olast[1]), .deser_data_val_o(oval[1]), .deser_data_rdy_i(crdy[1])
    );
    deserializer_pkt #(.DATA_W(8), .MSB_FIRST(1'b1)) u_w8_msb (
        .clk_i(clk), .srst_n_i(srst_n), .data_i(din[2]), .data_val_i(dval[2]),
        .data_last_i(dlast[2]), .data_rdy_o(drdy[2]), .deser_data_o(q2), .deser_len_o(l2),
        .deser_last_o(olast[2]), .deser_data_val_o(oval[2]), .deser_data_rdy_i(crdy[2])
    );

    always_comb begin
        odata[0] = 64'(q0);
        odata[1] = 64'(q1);
        odata[2] = 64'(q2);
        olen[0]  = 64'(l0);
        olen[1]  = 64'(l1);
        olen[2]  = 64'(l2);
    end

    int W[3]   = '{16, 8, 8};
    bit MSB[3] = '{1'b1, 1'b0, 1'b1};

    // Reference model: bits in arrival order plus one pending output word per instance.
    bit          m_bits[3][64];
    int          m_n[3];
    bit          m_val[3];
    bit          m_zero[3];
    logic [63:0] m_word[3];
    int          m_len[3];
    bit          m_last[3];
    bit          acc_q[3];

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int id = 0; id < 3; id++) begin
            m_n[id]    = 0;
            m_val[id]  = 1'b0;
            m_zero[id] = 1'b1;
            m_word[id] = '0;
            m_len[id]  = 0;
            m_last[id] = 1'b0;
        end
    endtask

    // Called just after a negedge with inputs set; models the next posedge and checks after it.
    task automatic cycle();
        bit          exp_rdy;
        bit          xfer;
        logic [63:0] w;
        #1;
        for (int id = 0; id < 3; id++) begin
            exp_rdy = !m_val[id] || crdy[id];
            check($sformatf("rdy%0d", id), 64'(drdy[id]), 64'(exp_rdy));
            acc_q[id] = 1'b0;
            if (srst_n) begin
                xfer = m_val[id] && crdy[id];
                if (dval[id] && exp_rdy) begin
                    acc_q[id] = 1'b1;
                    m_bits[id][m_n[id]] = din[id];
                    m_n[id]++;
                    if (m_n[id] == W[id] || dlast[id]) begin
                        w = '0;
                        for (int k = 0; k < m_n[id]; k++) begin
                            if (MSB[id]) w = w | (64'(m_bits[id][k]) << (m_n[id] - 1 - k));
                            else         w = w | (64'(m_bits[id][k]) << k);
                        end
                        m_word[id] = w;
                        m_len[id]  = m_n[id];
                        m_last[id] = dlast[id];
                        m_val[id]  = 1'b1;
                        m_zero[id] = 1'b0;
                        m_n[id]    = 0;
                    end else if (xfer) begin
                        m_val[id] = 1'b0;
                    end
                end else if (xfer) begin
                    m_val[id] = 1'b0;
                end
            end
        end
        if (!srst_n) model_reset();
        @(posedge clk);
        #1;
        for (int id = 0; id < 3; id++) begin
            check($sformatf("val%0d", id), 64'(oval[id]), 64'(m_val[id]));
            if (m_val[id] || m_zero[id]) begin
                check($sformatf("data%0d", id), odata[id], m_word[id]);
                check($sformatf("len%0d", id), olen[id], 64'(m_len[id]));
                check($sformatf("last%0d", id), 64'(olast[id]), 64'(m_last[id]));
            end
        end
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        for (int id = 0; id < 3; id++) begin
            din[id]   = 1'b0;
            dval[id]  = 1'b0;
            dlast[id] = 1'b0;
            crdy[id]  = 1'b1;
        end
    endtask

    task automatic send(input int id, input bit d, input bit l);
        int guard;
        din[id]   = d;
        dlast[id] = l;
        dval[id]  = 1'b1;
        guard     = 0;
        cycle();
        while (!acc_q[id] && guard < 200) begin
            cycle();
            guard++;
        end
        if (!acc_q[id]) begin
            check($sformatf("send_timeout%0d", id), 64'(0), 64'(1));
        end
        dval[id]  = 1'b0;
        dlast[id] = 1'b0;
    endtask

    task automatic send_word(input int id, input logic [63:0] w, input int n, input bit l);
        for (int k = 0; k < n; k++) begin
            if (MSB[id]) send(id, w[n-1-k], l && (k == n - 1));
            else         send(id, w[k], l && (k == n - 1));
        end
    endtask

    task automatic hold_or_new(input int id, input int val_pct);
        if (!(dval[id] && !acc_q[id])) begin
            din[id]   = 1'($urandom_range(0, 1));
            dval[id]  = ($urandom_range(0, 99) < val_pct);
            dlast[id] = ($urandom_range(0, 11) == 0);
        end
    endtask

    initial begin
        idle_inputs();
        model_reset();
        for (int id = 0; id < 3; id++) acc_q[id] = 1'b0;
        @(negedge clk);
        @(posedge clk);
        @(negedge clk);

        // Held reset with toggling valid: nothing may appear.
        for (int c = 0; c < 4; c++) begin
            for (int id = 0; id < 3; id++) begin
                dval[id] = 1'($urandom_range(0, 1));
                din[id]  = 1'($urandom_range(0, 1));
            end
            cycle();
        end
        idle_inputs();
        srst_n = 1'b1;
        cycle();

        // 0xA5C3 MSB first, then back-to-back words.
        send_word(0, 64'hA5C3, 16, 1'b0);
        check("a5c3_data", odata[0], 64'hA5C3);
        check("a5c3_len", olen[0], 64'd16);
        send_word(0, 64'h5A3C, 16, 1'b0);
        send_word(0, 64'hFFFF, 16, 1'b1);
        check("full_last", {olen[0][7:0], 7'd0, olast[0]}, {8'd16, 8'd1});
        cycle();

        // LSB short packet, then a full word starting again at bit 0.
        send(1, 1'b1, 1'b0);
        send(1, 1'b0, 1'b0);
        send(1, 1'b1, 1'b1);
        check("lsb_short", {odata[1][15:0], olen[1][7:0], 7'd0, olast[1]}, {16'h0005, 8'd3, 8'd1});
        send_word(1, 64'hC3, 8, 1'b0);
        check("lsb_full", odata[1], 64'hC3);

        // MSB short packet.
        send(2, 1'b1, 1'b0);
        send(2, 1'b1, 1'b0);
        send(2, 1'b0, 1'b1);
        check("msb_short", {odata[2][15:0], olen[2][7:0], 7'd0, olast[2]}, {16'h0006, 8'd3, 8'd1});
        cycle();

        // Backpressure: source always valid, consumer stalled then released.
        crdy[0] = 1'b0;
        for (int c = 0; c < 40; c++) begin
            if (!(dval[0] && !acc_q[0])) begin
                din[0]   = 1'($urandom_range(0, 1));
                dlast[0] = 1'b0;
            end
            dval[0] = 1'b1;
            if (c == 30) crdy[0] = 1'b1;
            cycle();
        end
        idle_inputs();
        cycle();
        cycle();

        // Reset mid-word discards partial bits.
        send_word(0, 64'h7F, 7, 1'b0);
        srst_n = 1'b0;
        cycle();
        srst_n = 1'b1;
        send_word(0, 64'h1234, 16, 1'b0);
        check("after_rst_data", odata[0], 64'h1234);
        check("after_rst_len", olen[0], 64'd16);
        cycle();

        // Random traffic on all instances with occasional resets.
        for (int c = 0; c < 3000; c++) begin
            for (int id = 0; id < 3; id++) begin
                hold_or_new(id, 75);
                crdy[id] = ($urandom_range(0, 99) < 65);
            end
            srst_n = ($urandom_range(0, 399) != 0);
            cycle();
        end
        srst_n = 1'b1;
        idle_inputs();
        cycle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
